// File: rtl/getir_birimi_pkg.sv
// getir_birimi_pkg -- shared definitions for the instruction fetch stage:
// fetch FSM state encoding, default reset PC and the instruction width.
package getir_birimi_pkg;

    localparam int BUYRUK_GENISLIK = 32;

    localparam logic [31:0] VARSAYILAN_BASLANGIC_ADRES = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        BEKLE = 2'd2,
        TUT   = 2'd3
    } getir_durum_t;

    // Instructions are word aligned, so redirect targets lose their low two bits.
    function automatic logic [31:0] hizala(input logic [31:0] adres);
        hizala = adres & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/getir_birimi.sv
// getir_birimi -- instruction fetch unit.
// Issues one memory request at a time from the PC, hands the returned word
// to the fetch/decode register, holds it while decode stalls and follows
// redirects from branch resolution. A redirect that lands while a request
// is still in flight marks that response as stale (iptal); the unit waits
// for it, throws it away, and only then requests the new target, so there
// is never more than one request outstanding.
// Optional build macro GETIR_PERF_SAYAC_EN adds getirilen_sayisi_o, a count
// of instructions delivered to buyruk_o.
module getir_birimi
    import getir_birimi_pkg::*;
#(
    parameter logic [31:0] BASLANGIC_ADRES = VARSAYILAN_BASLANGIC_ADRES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       durdur_i,
    input  logic                       atlama_gecerli_i,
    input  logic [31:0]                atlama_adres_i,
    output logic                       bellek_istek_o,
    output logic [31:0]                bellek_adres_o,
    input  logic                       bellek_hazir_i,
    input  logic                       bellek_gecerli_i,
    input  logic [BUYRUK_GENISLIK-1:0] bellek_buyruk_i,
    output logic [BUYRUK_GENISLIK-1:0] buyruk_o,
    output logic [31:0]                ps_o,
    output logic                       gecerli_o
`ifdef GETIR_PERF_SAYAC_EN
    ,
    output logic [31:0]                getirilen_sayisi_o
`endif
);

    getir_durum_t durum;
    logic [31:0]  ps;
    logic         iptal;
    logic [31:0]  ps_arti4;
    logic [31:0]  hedef;
    logic         yolda_kalir;

    assign ps_arti4 = ps + 32'd4;
    assign hedef    = hizala(atlama_adres_i);

    // A request is still in flight after this edge if memory accepts one now,
    // or if we are waiting and the response has not shown up yet.
    assign yolda_kalir = ((durum == ISTEK) && bellek_hazir_i) ||
                         ((durum == BEKLE) && !bellek_gecerli_i);

    // Fetch FSM: PC, request port and the registered instruction output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum          <= BOSTA;
            ps             <= BASLANGIC_ADRES;
            iptal          <= 1'b0;
            bellek_istek_o <= 1'b0;
            bellek_adres_o <= 32'h0000_0000;
            buyruk_o       <= '0;
            ps_o           <= 32'h0000_0000;
            gecerli_o      <= 1'b0;
        end else if (atlama_gecerli_i) begin
            ps        <= hedef;
            gecerli_o <= 1'b0;
            if (yolda_kalir) begin
                iptal          <= 1'b1;
                durum          <= BEKLE;
                bellek_istek_o <= 1'b0;
            end else begin
                iptal          <= 1'b0;
                durum          <= ISTEK;
                bellek_istek_o <= 1'b1;
                bellek_adres_o <= hedef;
            end
        end else begin
            case (durum)
                BOSTA: begin
                    durum          <= ISTEK;
                    bellek_istek_o <= 1'b1;
                    bellek_adres_o <= ps;
                end
                ISTEK: begin
                    gecerli_o <= 1'b0;
                    if (bellek_hazir_i) begin
                        durum          <= BEKLE;
                        bellek_istek_o <= 1'b0;
                    end
                end
                BEKLE: begin
                    if (bellek_gecerli_i) begin
                        if (iptal) begin
                            iptal          <= 1'b0;
                            durum          <= ISTEK;
                            bellek_istek_o <= 1'b1;
                            bellek_adres_o <= ps;
                        end else begin
                            buyruk_o  <= bellek_buyruk_i;
                            ps_o      <= ps;
                            gecerli_o <= 1'b1;
                            ps        <= ps_arti4;
                            if (durdur_i) begin
                                durum <= TUT;
                            end else begin
                                durum          <= ISTEK;
                                bellek_istek_o <= 1'b1;
                                bellek_adres_o <= ps_arti4;
                            end
                        end
                    end
                end
                TUT: begin
                    if (!durdur_i) begin
                        durum          <= ISTEK;
                        bellek_istek_o <= 1'b1;
                        bellek_adres_o <= ps;
                        gecerli_o      <= 1'b0;
                    end
                end
                default: begin
                    durum <= BOSTA;
                end
            endcase
        end
    end

`ifdef GETIR_PERF_SAYAC_EN
    logic teslim;

    assign teslim = !atlama_gecerli_i && (durum == BEKLE) &&
                    bellek_gecerli_i && !iptal;

    // Count instructions actually handed to decode; stale responses are skipped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            getirilen_sayisi_o <= 32'h0000_0000;
        end else if (teslim) begin
            getirilen_sayisi_o <= getirilen_sayisi_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_getir_birimi.sv
// tb_getir_birimi -- directed bench for getir_birimi.
// A small memory model answers accepted requests after a programmable
// number of extra wait cycles; data word = address ^ 32'h5A5A_0000 except
// 0x0 -> 32'h0000_0013 and 0x4 -> 32'hDEAD_BEEF.
// Build with GETIR_PERF_SAYAC_EN to also check the delivered-instruction counter.
module tb_getir_birimi;

    logic        clk_i;
    logic        rst_i;
    logic        durdur_i;
    logic        atlama_gecerli_i;
    logic [31:0] atlama_adres_i;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        bellek_hazir_i;
    logic        bellek_gecerli_i;
    logic [31:0] bellek_buyruk_i = 32'h0;
    logic [31:0] buyruk_o;
    logic [31:0] ps_o;
    logic        gecerli_o;
`ifdef GETIR_PERF_SAYAC_EN
    logic [31:0] getirilen_sayisi_o;
`endif

    logic        mem_gecerli = 1'b0;
    logic        zorla_gecerli;
    logic        bekleyen = 1'b0;
    logic [31:0] bekleyen_adres = 32'h0;
    int          sayac = 0;
    int          gecikme;

    int          vektor_sayisi = 0;
    int          hata_sayisi = 0;
    logic [127:0] gozlem;
    logic [127:0] beklenen;

    assign bellek_gecerli_i = mem_gecerli | zorla_gecerli;

    getir_birimi dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .durdur_i         (durdur_i),
        .atlama_gecerli_i (atlama_gecerli_i),
        .atlama_adres_i   (atlama_adres_i),
        .bellek_istek_o   (bellek_istek_o),
        .bellek_adres_o   (bellek_adres_o),
        .bellek_hazir_i   (bellek_hazir_i),
        .bellek_gecerli_i (bellek_gecerli_i),
        .bellek_buyruk_i  (bellek_buyruk_i),
        .buyruk_o         (buyruk_o),
        .ps_o             (ps_o),
        .gecerli_o        (gecerli_o)
`ifdef GETIR_PERF_SAYAC_EN
        ,
        .getirilen_sayisi_o (getirilen_sayisi_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] oku(input logic [31:0] adres);
        if (adres == 32'h0000_0000)      oku = 32'h0000_0013;
        else if (adres == 32'h0000_0004) oku = 32'hDEAD_BEEF;
        else                             oku = adres ^ 32'h5A5A_0000;
    endfunction

    // Memory model: accepts on istek && hazir, answers for one cycle after gecikme extra cycles.
    always @(posedge clk_i) begin
        mem_gecerli <= 1'b0;
        if (bekleyen) begin
            if (sayac == 0) begin
                mem_gecerli     <= 1'b1;
                bellek_buyruk_i <= oku(bekleyen_adres);
                bekleyen        <= 1'b0;
            end else begin
                sayac <= sayac - 1;
            end
        end else if (bellek_istek_o && bellek_hazir_i) begin
            if (gecikme == 0) begin
                mem_gecerli     <= 1'b1;
                bellek_buyruk_i <= oku(bellek_adres_o);
            end else begin
                bekleyen       <= 1'b1;
                bekleyen_adres <= bellek_adres_o;
                sayac          <= gecikme - 1;
            end
        end
    end

    task automatic saat();
        @(posedge clk_i);
        #1;
    endtask

    // Reset asserted asynchronously, then held across clock edges.
    task automatic test_reset();
        #2 rst_i = 1'b1;
        #1;
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL reset_async: got %h expected %h", gozlem, beklenen); end
        saat();
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL reset_held: got %h expected %h", gozlem, beklenen); end
    endtask

    // First fetch from address 0 with a zero-wait memory.
    task automatic test_ilk_getirme();
        rst_i = 1'b0;
        #1;
        gozlem   = {bellek_istek_o};
        beklenen = {1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL ilk_bosta: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o};
        beklenen = {1'b1, 32'h0, 1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL ilk_istek: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem   = {bellek_istek_o, gecerli_o};
        beklenen = {1'b0, 1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL ilk_bekle: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0013};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL ilk_teslim: got %h expected %h", gozlem, beklenen); end
    endtask

    // Stall for 4 cycles after the 0x4 response, then resume at 0x8.
    task automatic test_durdur();
        saat();
        gozlem   = {bellek_istek_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b0, 1'b0, 32'h0, 32'h0000_0013};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL durdur_dusus: got %h expected %h", gozlem, beklenen); end
        durdur_i = 1'b1;
        saat();
        gozlem   = {bellek_istek_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL durdur_teslim: got %h expected %h", gozlem, beklenen); end
        for (int i = 0; i < 3; i++) begin
            saat();
            gozlem = {bellek_istek_o, gecerli_o, ps_o, buyruk_o};
            vektor_sayisi++;
            if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL durdur_tut%0d: got %h expected %h", i, gozlem, beklenen); end
        end
        durdur_i = 1'b0;
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h8, 1'b0, 32'h4, 32'hDEAD_BEEF};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL durdur_devam: got %h expected %h", gozlem, beklenen); end
    endtask

    // Memory not ready for 3 cycles: request must stay put.
    task automatic test_hazir_bekleme();
        bellek_hazir_i = 1'b0;
        beklenen = {1'b1, 32'h8};
        for (int i = 0; i < 3; i++) begin
            saat();
            gozlem = {bellek_istek_o, bellek_adres_o};
            vektor_sayisi++;
            if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL hazir_tut%0d: got %h expected %h", i, gozlem, beklenen); end
        end
        bellek_hazir_i = 1'b1;
        saat();
        gozlem   = {bellek_istek_o, gecerli_o};
        beklenen = {1'b0, 1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL hazir_kabul: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'hC, 1'b1, 32'h8, 32'h5A5A_0008};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL hazir_teslim: got %h expected %h", gozlem, beklenen); end
    endtask

    // Redirect to 0x1002 in BEKLE, coincident with the 0xC response.
    task automatic test_atlama_bekle();
        saat();
        atlama_gecerli_i = 1'b1;
        atlama_adres_i   = 32'h0000_1002;
        saat();
        atlama_gecerli_i = 1'b0;
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h1000, 1'b0, 32'h8, 32'h5A5A_0008};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL atlama_bekle: got %h expected %h", gozlem, beklenen); end
    endtask

    // Redirect while the 0x1000 response is still two cycles away.
    task automatic test_iptal();
        gecikme = 2;
        saat();
        atlama_gecerli_i = 1'b1;
        atlama_adres_i   = 32'h0000_2003;
        saat();
        atlama_gecerli_i = 1'b0;
        gozlem   = {bellek_istek_o, gecerli_o};
        beklenen = {1'b0, 1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL iptal_kur: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem = {bellek_istek_o, gecerli_o};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL iptal_bekle: got %h expected %h", gozlem, beklenen); end
        gecikme = 0;
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h2000, 1'b0, 32'h8, 32'h5A5A_0008};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL iptal_at: got %h expected %h", gozlem, beklenen); end
        saat();
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h2004, 1'b1, 32'h2000, 32'h5A5A_2000};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL iptal_sonra: got %h expected %h", gozlem, beklenen); end
    endtask

    // Redirect and stall together while holding in TUT.
    task automatic test_atlama_tut();
        saat();
        durdur_i = 1'b1;
        saat();
        gozlem   = {bellek_istek_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b0, 1'b1, 32'h2004, 32'h5A5A_2004};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL tut_gir: got %h expected %h", gozlem, beklenen); end
        atlama_gecerli_i = 1'b1;
        atlama_adres_i   = 32'h0000_3000;
        saat();
        atlama_gecerli_i = 1'b0;
        durdur_i         = 1'b0;
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o};
        beklenen = {1'b1, 32'h3000, 1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL tut_atlama: got %h expected %h", gozlem, beklenen); end
        saat();
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h3004, 1'b1, 32'h3000, 32'h5A5A_3000};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL tut_teslim: got %h expected %h", gozlem, beklenen); end
    endtask

    // Redirect in ISTEK as memory accepts, to 0xFFFFFFFC; then PC wraps to 0.
    task automatic test_sarma();
        atlama_gecerli_i = 1'b1;
        atlama_adres_i   = 32'hFFFF_FFFF;
        saat();
        atlama_gecerli_i = 1'b0;
        gozlem   = {bellek_istek_o, gecerli_o};
        beklenen = {1'b0, 1'b0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL sarma_iptal: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h3000, 32'h5A5A_3000};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL sarma_at: got %h expected %h", gozlem, beklenen); end
        saat();
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFFC};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL sarma_teslim: got %h expected %h", gozlem, beklenen); end
`ifdef GETIR_PERF_SAYAC_EN
        gozlem   = {getirilen_sayisi_o};
        beklenen = {32'd7};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL sayac_7: got %h expected %h", gozlem, beklenen); end
`endif
    endtask

    // A response strobe while in ISTEK must not reach the outputs.
    task automatic test_gecersiz_yanit();
        bellek_hazir_i = 1'b0;
        zorla_gecerli  = 1'b1;
        saat();
        zorla_gecerli = 1'b0;
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hA5A5_FFFC};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL gecersiz_yanit: got %h expected %h", gozlem, beklenen); end
        saat();
        gozlem = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL gecersiz_sonra: got %h expected %h", gozlem, beklenen); end
        bellek_hazir_i = 1'b1;
    endtask

    // Reset with a request in flight; the late response arrives in BOSTA.
    task automatic test_reset_ortasi();
        gecikme = 1;
        saat();
        rst_i = 1'b1;
        #1;
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL orta_reset: got %h expected %h", gozlem, beklenen); end
`ifdef GETIR_PERF_SAYAC_EN
        gozlem   = {getirilen_sayisi_o};
        beklenen = {32'd0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL sayac_reset: got %h expected %h", gozlem, beklenen); end
`endif
        saat();
        rst_i   = 1'b0;
        gecikme = 0;
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL orta_bosta: got %h expected %h", gozlem, beklenen); end
        saat();
        saat();
        gozlem   = {bellek_istek_o, bellek_adres_o, gecerli_o, ps_o, buyruk_o};
        beklenen = {1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0013};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL orta_teslim: got %h expected %h", gozlem, beklenen); end
`ifdef GETIR_PERF_SAYAC_EN
        gozlem   = {getirilen_sayisi_o};
        beklenen = {32'd1};
        vektor_sayisi++;
        if (gozlem !== beklenen) begin hata_sayisi++; $display("[TB] FAIL sayac_1: got %h expected %h", gozlem, beklenen); end
`endif
    endtask

    // Run every scenario in order, then report.
    initial begin
        clk_i            = 1'b0;
        rst_i            = 1'b0;
        durdur_i         = 1'b0;
        atlama_gecerli_i = 1'b0;
        atlama_adres_i   = 32'h0;
        bellek_hazir_i   = 1'b1;
        zorla_gecerli    = 1'b0;
        gecikme          = 0;
        test_reset();
        test_ilk_getirme();
        test_durdur();
        test_hazir_bekleme();
        test_atlama_bekle();
        test_iptal();
        test_atlama_tut();
        test_sarma();
        test_gecersiz_yanit();
        test_reset_ortasi();
        $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
        $finish;
    end

endmodule

// File: doc/getir_birimi.md
GETIR_BIRIMI -- requirements
Module: getir_birimi

Interface
REQ-001 The block SHALL expose parameter BASLANGIC_ADRES, default 32'h0000_0000: the first fetch address after reset.
REQ-002 clk_i  input  1  Clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  Reset, asynchronous, active-high.
REQ-004 durdur_i  input  1  Stall from the decode side; the output instruction is held while it is high.
REQ-005 atlama_gecerli_i  input  1  Redirect request from branch resolution.
REQ-006 atlama_adres_i  input  32  Redirect target address.
REQ-007 bellek_istek_o  output  1  Instruction memory request valid.
REQ-008 bellek_adres_o  output  32  Instruction memory request address.
REQ-009 bellek_hazir_i  input  1  Memory accepts the request this cycle.
REQ-010 bellek_gecerli_i  input  1  Memory response valid.
REQ-011 bellek_buyruk_i  input  32  Memory response instruction word.
REQ-012 buyruk_o  output  32  Fetched instruction to the fetch/decode pipeline register.
REQ-013 ps_o  output  32  Address of buyruk_o.
REQ-014 gecerli_o  output  1  buyruk_o/ps_o carry a valid instruction.

Function
REQ-015 FSM states SHALL be BOSTA, ISTEK, BEKLE and TUT; at most one memory request SHALL be outstanding.
REQ-016 BOSTA -> ISTEK SHALL occur on the first clock edge after rst_i is released.
REQ-017 ISTEK: bellek_istek_o=1 and bellek_adres_o=ps; on bellek_hazir_i=1 -> BEKLE; request held stable until accepted.
REQ-018 BEKLE: on bellek_gecerli_i=1, buyruk_o<=bellek_buyruk_i, ps_o<=ps, gecerli_o<=1, ps<=ps+4 (mod 2^32 wrap); then -> ISTEK if durdur_i=0, else -> TUT.
REQ-019 A response arriving in BEKLE with durdur_i=0 SHALL be consumed downstream on the next edge; gecerli_o SHALL fall to 0 on that edge unless a new response arrives on it.
REQ-020 TUT: buyruk_o, ps_o, gecerli_o held; no request issued; -> ISTEK on the first cycle durdur_i=0.
REQ-021 Redirect (atlama_gecerli_i=1) SHALL have priority over every other event including durdur_i: ps<=atlama_adres_i with bits [1:0] forced to 0, gecerli_o<=0, next state ISTEK.
REQ-022 Redirect in BEKLE, or in ISTEK coincident with bellek_hazir_i=1, SHALL set an iptal flag; the next response SHALL be discarded (no output change), iptal cleared, then ISTEK for the new ps.
REQ-023 bellek_gecerli_i outside BEKLE SHALL be ignored.
REQ-024 Minimum fetch rate SHALL be one instruction every 2 cycles (zero-wait memory).

Reset
REQ-025 On rst_i=1, immediately and regardless of clock: state=BOSTA, ps=BASLANGIC_ADRES, iptal=0, bellek_istek_o=0, bellek_adres_o=0, buyruk_o=0, ps_o=0, gecerli_o=0.
REQ-026 Reset mid-request SHALL abandon the outstanding request; any response arriving in BOSTA SHALL be ignored.

Configuration
REQ-027 With GETIR_PERF_SAYAC_EN defined, the block SHALL add output getirilen_sayisi_o (32 bits) counting responses delivered to buyruk_o (discarded ones excluded), reset to 0, wrapping at 2^32.
REQ-028 Without GETIR_PERF_SAYAC_EN the port and counter SHALL not exist; all other behaviour is identical.

Structure
REQ-029 FSM state encoding, BASLANGIC_ADRES default and the instruction-width constant (32) SHALL live in the shared pipeline package.
REQ-030 The block SHALL be a single module; the PC register and +4 adder stay inline, no sub-module.

Verification
REQ-031 Reset release, memory zero-wait returning 32'h0000_0013 -> first request address 0x0 on cycle 1, gecerli_o=1, ps_o=0x0, buyruk_o=32'h0000_0013 on cycle 3, next request address 0x4.
REQ-032 bellek_hazir_i low for 3 cycles in ISTEK -> bellek_istek_o and bellek_adres_o=0x8 held stable all 3 cycles.
REQ-033 durdur_i high 4 cycles after response 32'hDEAD_BEEF at 0x4 -> outputs held, no bellek_istek_o, resumes fetch at 0x8 after release.
REQ-034 Redirect to 32'h0000_1002 while in BEKLE -> response discarded, gecerli_o=0, next request address 0x1000.
REQ-035 Redirect and durdur_i both high in TUT -> gecerli_o=0 next cycle, request at target issued.
REQ-036 ps=32'hFFFF_FFFC fetched -> next request address 0x0; with GETIR_PERF_SAYAC_EN, counter equals delivered count, excludes discarded response.
